// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a single-outstanding bus master.
// Aligned loads/stores run IDLE -> WAIT -> DONE. A flush during WAIT
// cannot abort the bus transfer, so the stage waits it out in DRAIN.

package mem_stage_pkg;
   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
endpackage

module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ex_wd,
   input  logic        ex_wreg,
   input  logic [31:0] ex_wdata,
   input  logic [7:0]  ex_aluop,
   input  logic [31:0] ex_mem_addr,
   input  logic [31:0] ex_reg2,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_wdata,
   output logic        stallreq,
   output logic [4:0]  mem_wd,
   output logic        mem_wreg,
   output logic [31:0] mem_wdata,
   output logic        adel,
   output logic        ades
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

   state_t      state_q, state_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_sel_q, bus_sel_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [31:0] rdata_q, rdata_d;

   logic        is_load, is_store, is_mem, is_byte, is_half, is_word, is_signed;
   logic        misaligned, issue_ok;
   logic [3:0]  req_sel;
   logic [31:0] req_wdata;
   logic [31:0] load_data;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // Only stall[4] (MEM held) matters to this stage.
   logic unused_stall;
   assign unused_stall = ^{stall[5], stall[3:0]};

   // Decode the operation into access kind, size and signedness.
   // NOTE: every signal written in an always_comb gets a default first so
   // no path leaves it unassigned, which would infer a latch.
   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_byte   = 1'b0;
      is_half   = 1'b0;
      is_word   = 1'b0;
      is_signed = 1'b0;
      case (ex_aluop)
         EXE_LB_OP:  begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
         EXE_LBU_OP: begin is_load  = 1'b1; is_byte = 1'b1; end
         EXE_LH_OP:  begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
         EXE_LHU_OP: begin is_load  = 1'b1; is_half = 1'b1; end
         EXE_LW_OP:  begin is_load  = 1'b1; is_word = 1'b1; end
         EXE_SB_OP:  begin is_store = 1'b1; is_byte = 1'b1; end
         EXE_SH_OP:  begin is_store = 1'b1; is_half = 1'b1; end
         EXE_SW_OP:  begin is_store = 1'b1; is_word = 1'b1; end
         default:    ;
      endcase
   end

   assign is_mem     = is_load | is_store;
   assign misaligned = (is_half & ex_mem_addr[0]) | (is_word & (|ex_mem_addr[1:0]));
   assign issue_ok   = is_mem & ~misaligned;
   assign adel       = is_load & misaligned;
   assign ades       = is_store & misaligned;

   // Big-endian byte lanes and lane-replicated store data for a new request.
   always_comb begin
      req_sel   = 4'b1111;
      req_wdata = ex_reg2;
      if (is_byte) begin
         req_sel   = 4'b1000 >> ex_mem_addr[1:0];
         req_wdata = {4{ex_reg2[7:0]}};
      end else if (is_half) begin
         req_sel   = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
         req_wdata = {2{ex_reg2[15:0]}};
      end
   end

   // Extract and extend the addressed lane from the captured read word.
   always_comb begin
      case (ex_mem_addr[1:0])
         2'd0:    rd_byte = rdata_q[31:24];
         2'd1:    rd_byte = rdata_q[23:16];
         2'd2:    rd_byte = rdata_q[15:8];
         default: rd_byte = rdata_q[7:0];
      endcase
      rd_half = ex_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
      if (is_byte)
         load_data = {{24{is_signed & rd_byte[7]}}, rd_byte};
      else if (is_half)
         load_data = {{16{is_signed & rd_half[15]}}, rd_half};
      else
         load_data = rdata_q;
   end

   // Next-state, bus register updates and combinational stage results.
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_sel_d   = bus_sel_q;
      bus_wdata_d = bus_wdata_q;
      rdata_d     = rdata_q;
      mem_wd      = ex_wd;
      mem_wreg    = ex_wreg;
      mem_wdata   = ex_wdata;
      stallreq    = 1'b0;

      case (state_q)
         IDLE: begin
            if (is_mem || flush)
               mem_wreg = 1'b0;
            if (!flush && issue_ok) begin
               stallreq    = 1'b1;
               state_d     = WAIT;
               bus_req_d   = 1'b1;
               bus_we_d    = is_store;
               bus_addr_d  = {ex_mem_addr[31:2], 2'b00};
               bus_sel_d   = req_sel;
               bus_wdata_d = req_wdata;
            end
         end

         WAIT: begin
            mem_wreg = 1'b0;
            if (bus_ack) begin
               bus_req_d = 1'b0;
               bus_we_d  = 1'b0;
               rdata_d   = bus_rdata;
               stallreq  = ~flush;
               state_d   = flush ? IDLE : DONE;
            end else if (flush) begin
               // The slave still owes an ack; wait it out rather than abort.
               state_d = DRAIN;
            end else begin
               stallreq = 1'b1;
            end
         end

         DONE: begin
            if (is_load)
               mem_wdata = load_data;
            if (is_store || flush)
               mem_wreg = 1'b0;
            if (flush || !stall[4])
               state_d = IDLE;
         end

         DRAIN: begin
            if (is_mem || flush)
               mem_wreg = 1'b0;
            stallreq = issue_ok & ~flush;
            if (bus_ack) begin
               bus_req_d = 1'b0;
               bus_we_d  = 1'b0;
               state_d   = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and bus registers; reset abandons any transfer in flight.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_sel_q   <= '0;
         bus_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_sel_q   <= bus_sel_d;
         bus_wdata_q <= bus_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_sel   = bus_sel_q;
   assign bus_wdata = bus_wdata_q;

endmodule
